// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg: shared widths, load op codes and EX/MEM/WB payload layouts.
package mem_stage_lsu_pkg;
    localparam int TO_MEM_W = 76;
    localparam int TO_WB_W  = 71;
    localparam int FWD_W    = 37;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_H  = 3'd2,
        LD_BU = 3'd3,
        LD_HU = 3'd4
    } mem_op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic        gr_we;
        logic        res_from_mem;
        logic [2:0]  mem_op;
        logic        ex_sys;
        logic        req_issued;
    } to_mem_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic        gr_we;
        logic        ex_sys;
    } to_wb_t;
endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// load_align: byte/halfword extraction and extension of a loaded word.
module load_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  mem_op,
    output logic [31:0] result
);
    logic [31:0] shifted;
    mem_op_e     op;
    assign shifted = word >> {addr, 3'b000};
    assign op      = mem_op_e'(mem_op);
    // reserved encodings fall through to a full word
    always_comb begin
        result = op == LD_B  ? {{24{shifted[7]}}, shifted[7:0]} :
                 op == LD_H  ? {{16{shifted[15]}}, shifted[15:0]} :
                 op == LD_BU ? {24'd0, shifted[7:0]} :
                 op == LD_HU ? {16'd0, shifted[15:0]} : word;
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM pipeline stage; waits for load data, aligns it and hands results to WB.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int CANCEL_W = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [TO_MEM_W-1:0] to_MEM_data,
    input  logic                EX_to_MEM_valid,
    output logic                MEM_allow_in,
    output logic [TO_WB_W-1:0]  to_WB_data,
    output logic                MEM_to_WB_valid,
    input  logic                WB_allow_in,
    input  logic                data_sram_data_ok,
    input  logic [31:0]         data_sram_rdata,
    input  logic                wb_ex,
    input  logic                EX_req_pending,
    output logic [FWD_W-1:0]    MEM_forward,
    output logic                MEM_load_pending,
    output logic                MEM_ex_pending
);
    localparam logic [CANCEL_W:0] CANCEL_MAX = {1'b0, {CANCEL_W{1'b1}}};

    to_mem_t             d;
    logic                mem_valid;
    logic                rbuf_valid;
    logic [31:0]         rbuf;
    logic [CANCEL_W-1:0] cancel_cnt;
    logic [CANCEL_W:0]   cancel_inc;
    logic [CANCEL_W:0]   cancel_nxt;
    logic                cancel_dec;
    logic                need_resp;
    logic                ok_eff;
    logic                have_data;
    logic                ready_go;
    logic                handshake;
    logic                capture;
    logic [31:0]         load_word;
    logic [31:0]         load_data;
    logic [31:0]         final_result;

    assign need_resp    = d.res_from_mem & d.req_issued;
    // responses owed to flushed instructions never reach the data path
    assign ok_eff       = data_sram_data_ok & (cancel_cnt == '0);
    assign have_data    = rbuf_valid | ok_eff;
    assign ready_go     = ~need_resp | have_data;
    assign MEM_allow_in = ~mem_valid | (ready_go & WB_allow_in);
    assign MEM_to_WB_valid  = mem_valid & ready_go & ~wb_ex;
    assign MEM_load_pending = mem_valid & need_resp & ~have_data;
    assign MEM_ex_pending   = mem_valid & d.ex_sys;
    assign handshake    = MEM_to_WB_valid & WB_allow_in;
    assign capture      = mem_valid & need_resp & ok_eff & ~WB_allow_in & ~rbuf_valid;
    assign load_word    = rbuf_valid ? rbuf : data_sram_rdata;

    load_align u_load_align (
        .word   (load_word),
        .addr   (d.alu_result[1:0]),
        .mem_op (d.mem_op),
        .result (load_data)
    );

    assign final_result = d.res_from_mem ? load_data : d.alu_result;
    assign to_WB_data   = {d.pc, d.dest, final_result, d.gr_we, d.ex_sys};
    assign MEM_forward  = {d.dest & {5{mem_valid}}, final_result};

    assign cancel_inc = wb_ex ? (CANCEL_W+1)'(MEM_load_pending) + (CANCEL_W+1)'(EX_req_pending) : '0;
    assign cancel_dec = data_sram_data_ok & (cancel_cnt != '0);
    assign cancel_nxt = {1'b0, cancel_cnt} + cancel_inc - (CANCEL_W+1)'(cancel_dec);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid  <= 1'b0;
            d          <= '0;
            rbuf_valid <= 1'b0;
            rbuf       <= '0;
            cancel_cnt <= '0;
        end else begin
            mem_valid  <= wb_ex ? 1'b0 : MEM_allow_in ? EX_to_MEM_valid : mem_valid;
            if (EX_to_MEM_valid & MEM_allow_in)
                d <= to_MEM_data;
            rbuf_valid <= (wb_ex | handshake) ? 1'b0 : capture ? 1'b1 : rbuf_valid;
            if (capture)
                rbuf <= data_sram_rdata;
            cancel_cnt <= cancel_nxt > CANCEL_MAX ? CANCEL_MAX[CANCEL_W-1:0] : cancel_nxt[CANCEL_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (resetn)
            assert (cancel_nxt <= CANCEL_MAX);
    end
endmodule
